// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : PC holder and instruction fetcher feeding instruction_decode over
//            a variable-latency Req/Rdy instruction memory interface.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hFFFF_FFFF,
    parameter int          TIMEOUT   = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_LdEn,
    input  logic        PC_sel,
    input  logic [31:0] PC_Immed,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Rdy,
    input  logic [31:0] Mem_Data,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic        Fetch_Err
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    logic [1:0]         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;

    logic [31:0] w_pc_seq;
    logic [31:0] w_imm_shift;
    logic [31:0] w_pc_next;

    // The shift drops the offset's top two bits; the sum wraps modulo 2^32.
    assign w_imm_shift = PC_Immed << 2;
    assign w_pc_seq    = r_pc + 32'd4;
    assign w_pc_next   = PC_sel ? (w_pc_seq + w_imm_shift) : w_pc_seq;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // A returned word wins over a timeout on the same edge.
                    if (Mem_Rdy) begin
                        r_instr <= Mem_Data;
                        r_cnt   <= '0;
                        r_state <= S_VALID;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_instr <= NOP_INSTR;
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_VALID;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_VALID: begin
                    if (PC_LdEn) begin
                        r_pc    <= w_pc_next;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Mem_Req     = (r_state == S_FETCH);
    assign Instr_Valid = (r_state == S_VALID);
    assign Mem_Addr    = r_pc;
    assign PC          = r_pc;
    assign Instr       = r_instr;
    assign Fetch_Err   = r_err;

endmodule

`default_nettype wire
